seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised serial sequence detector. It is the next generation of the team's fixed single-pattern FSM_1 detector.
- Samples a 1-bit serial stream under an enable and flags every occurrence of a PAT_W-bit pattern.
- The pattern is reloadable at run time.
- Overlapping or non-overlapping matching is selectable, and a saturating match counter is kept.
- Used as a front-end event detector for serial control links.

Parameters:
PAT_W, 4, pattern length in bits (legal range 2..16)
PATTERN, 4'b1011, reset value of the pattern register (MSB is the first bit received)
OVERLAP, 1, 1 = overlapping matches allowed; 0 = history discarded after each match
CNT_W, 8, width of the match counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
en  input  1  sample enable; in is sampled only when en=1
in  input  1  serial data bit
cfg_load  input  1  load cfg_pattern into the pattern register
cfg_pattern  input  PAT_W  new pattern
clr_cnt  input  1  clear match_cnt
det  output  1  combinational (Mealy) match indication for the current bit
out  output  1  registered (Moore) one-cycle match pulse
match_cnt  output  CNT_W  saturating count of matches

Behaviour:
- Registers:
  - pat[PAT_W-1:0]
  - hist[PAT_W-1:0]
  - fill, width $clog2(PAT_W+1), saturating at PAT_W
  - out
  - match_cnt
- Reset (clk edge with reset=1): pat<=PATTERN, hist<=0, fill<=0, out<=0, match_cnt<=0. reset overrides every other input. Reset mid-stream discards any partial match.
- Candidate word: cand = {hist[PAT_W-2:0], in}.
- Match logic: hit = en & ~cfg_load & (fill >= PAT_W-1) & (cand == pat). det = hit, purely combinational.
- Priority at each clk edge when reset=0: cfg_load > en > idle.
- cfg_load=1:
  - pat<=cfg_pattern, hist<=0, fill<=0, out<=0.
  - en and in are ignored that cycle.
  - match_cnt is unaffected, except that clr_cnt still applies.
- en=1, cfg_load=0:
  - hist<=cand.
  - fill<=min(fill+1, PAT_W).
  - out<=hit.
  - If hit and OVERLAP=0, fill<=0 instead. The next match then needs PAT_W fresh bits.
- en=0, cfg_load=0: hist and fill hold, out<=0. Gaps in en do not break a partial match.
- Latency:
  - det asserts in the same cycle as the final pattern bit.
  - out asserts for exactly one cycle after the edge that sampled the final bit.
  - Back-to-back matches (e.g. all-ones pattern with OVERLAP=1) give out high on consecutive cycles.
- match_cnt:
  - On an edge with hit=1, it increments and saturates at 2^CNT_W-1 (no wrap).
  - clr_cnt=1 takes priority over the increment: match_cnt<=0 when hit=0, and match_cnt<=1 when hit=1 on the same edge.
- Fill gating: no match is reported until PAT_W valid bits have been received since the last reset, cfg_load or non-overlap match. A pattern of all zeros therefore cannot match on the reset-zero history.
- Internal FSM: fill encodes the states EMPTY(0), FILLING(1..PAT_W-1) and PRIMED(PAT_W).
  - EMPTY → FILLING on en.
  - FILLING → PRIMED when fill reaches PAT_W.
  - PRIMED → EMPTY on hit with OVERLAP=0, on cfg_load, or on reset.

Test Plan:
1. Defaults (PAT_W=4, pat=1011, OVERLAP=1), en=1, stream 1,0,1,1,0,1,1 → det high on bits 4 and 7; out high in the cycles after them; match_cnt=2.
2. Same stream with OVERLAP=0 → a single match at bit 4; match_cnt=1; no match at bit 7.
3. Stream 1,0,1,1 with en dropped for 3 cycles between bits 2 and 3 → exactly one match; out low during the en=0 cycles.
4. cfg_load with cfg_pattern=4'b0000, then 4 zeros → det=0 on zeros 1–3 (fill gating), det=1 on the 4th zero; match_cnt=1.
5. CNT_W=2, all-ones pattern 1111, OVERLAP=1, 8 ones → out high on 5 consecutive cycles; match_cnt saturates at 3. Then clr_cnt coincident with a hit → match_cnt=1.
6. Assert reset after bits 1,0,1 of 1011, then send 1 → no match; match_cnt=0; out=0; pat back to 1011 after a prior cfg_load.

Source files
------------

// File: rtl/seq_detector_param.sv
// seq_detector_param: serial pattern detector with run-time reloadable pattern.
//
// Samples `in` whenever `en` is high and flags each occurrence of a PAT_W-bit
// pattern (MSB is the first bit received). Matches may overlap (OVERLAP=1) or
// restart from an empty history after each hit (OVERLAP=0). A saturating
// counter tallies matches.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   en          sample enable for `in`
//   in          serial data bit
//   cfg_load    load cfg_pattern into the pattern register (clears history)
//   cfg_pattern new pattern, PAT_W bits
//   clr_cnt     clear match_cnt (a coincident hit leaves it at 1)
//   det         combinational match indication for the current bit
//   out         registered one-cycle match pulse
//   match_cnt   saturating match count, CNT_W bits
module seq_detector_param #(
  parameter int unsigned      PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit               OVERLAP = 1'b1,
  parameter int unsigned      CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             clr_cnt,
  output logic             det,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned FW = $clog2(PAT_W + 1);

  // fill doubles as the state: 0 = empty, 1..PAT_W-1 = filling, PAT_W = primed.
  localparam logic [FW-1:0]    FillFull  = FW'(PAT_W);
  localparam logic [FW-1:0]    FillReady = FW'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PAT_W-1:0] cand;
  logic             hit;

  always_comb begin
    cand = {hist_q[PAT_W-2:0], in};
    // Once PAT_W-1 bits are held, the current bit completes a full word.
    hit  = en & ~cfg_load & (fill_q >= FillReady) & (cand == pat_q);
  end

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    out_d  = 1'b0;
    cnt_d  = cnt_q;

    if (cfg_load) begin
      pat_d  = cfg_pattern;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d = cand;
      fill_d = (fill_q == FillFull) ? FillFull : fill_q + FW'(1);
      out_d  = hit;
      // Non-overlapping mode: the next match needs PAT_W fresh bits.
      if (hit && !OVERLAP) begin
        fill_d = '0;
      end
    end

    if (clr_cnt) begin
      cnt_d = hit ? CNT_W'(1) : '0;
    end else if (hit && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q  <= PATTERN;
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
    end
  end

  assign det       = hit;
  assign out       = out_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param. Three instances share one
// stimulus: default (overlap, 8-bit count), non-overlap, and a 2-bit counter.
// Each is compared against a bit-queue reference model.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset, en, din, cfg_load, clr_cnt;
  logic [3:0] cfg_pattern;

  logic       det_w [3];
  logic       out_w [3];
  logic [7:0] cnt_w [3];
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ovl (
    .clk(clk), .reset(reset), .en(en), .in(din), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .clr_cnt(clr_cnt), .det(det_w[0]), .out(out_w[0]),
    .match_cnt(cnt0)
  );

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_novl (
    .clk(clk), .reset(reset), .en(en), .in(din), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .clr_cnt(clr_cnt), .det(det_w[1]), .out(out_w[1]),
    .match_cnt(cnt1)
  );

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .en(en), .in(din), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .clr_cnt(clr_cnt), .det(det_w[2]), .out(out_w[2]),
    .match_cnt(cnt2)
  );

  assign cnt_w[0] = cnt0;
  assign cnt_w[1] = cnt1;
  assign cnt_w[2] = {6'b0, cnt2};

  // Reference model: the bits received since the last clear (newest at back,
  // at most 3 kept), the current pattern, last pulse and match count.
  bit   hq   [3][$];
  int   mpat [3];
  bit   mout [3];
  int   mcnt [3];
  bit   movl [3] = '{1'b1, 1'b0, 1'b1};
  int   mmax [3] = '{255, 255, 3};

  task automatic check(string tag, int idx, logic [7:0] obs, logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  function automatic bit mhit(int i, bit e, bit d, bit ld);
    int w;
    if (!e || ld || hq[i].size() < 3) return 1'b0;
    w = 0;
    for (int k = 0; k < hq[i].size(); k++) w = w * 2 + int'(hq[i][k]);
    w = w * 2 + int'(d);
    return w == mpat[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      hq[i].delete();
      mpat[i] = 4'b1011;
      mout[i] = 1'b0;
      mcnt[i] = 0;
    end
  endtask

  // One clock: drive at the falling edge, check det mid-cycle, then check
  // out/match_cnt just after the rising edge.
  task automatic step(bit e, bit d, bit ld, logic [3:0] np, bit clr, bit rst);
    bit h [3];
    @(negedge clk);
    en = e; din = d; cfg_load = ld; cfg_pattern = np; clr_cnt = clr; reset = rst;
    #1;
    for (int i = 0; i < 3; i++) begin
      h[i] = mhit(i, e, d, ld);
      check("det", i, {7'b0, det_w[i]}, {7'b0, h[i]});
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        hq[i].delete();
        mpat[i] = 4'b1011;
        mout[i] = 1'b0;
        mcnt[i] = 0;
      end else begin
        if (ld) begin
          hq[i].delete();
          mpat[i] = int'(np);
          mout[i] = 1'b0;
        end else if (e) begin
          mout[i] = h[i];
          if (h[i] && !movl[i]) begin
            hq[i].delete();
          end else begin
            hq[i].push_back(d);
            if (hq[i].size() > 3) void'(hq[i].pop_front());
          end
        end else begin
          mout[i] = 1'b0;
        end
        if (clr) mcnt[i] = h[i] ? 1 : 0;
        else if (h[i] && mcnt[i] < mmax[i]) mcnt[i]++;
      end
      check("out", i, {7'b0, out_w[i]}, {7'b0, mout[i]});
      check("match_cnt", i, cnt_w[i], 8'(mcnt[i]));
    end
  endtask

  task automatic send(bit d);
    step(1'b1, d, 1'b0, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; din = 1'b0; cfg_load = 1'b0; cfg_pattern = '0; clr_cnt = 1'b0;
    model_reset();

    // Reset state
    do_reset();
    do_reset();
    check("reset_cnt", 0, cnt0, 8'd0);
    check("reset_out", 0, {7'b0, out_w[0]}, 8'd0);

    // Stream 1011011: overlap hits twice, non-overlap once
    send(1); send(0); send(1); send(1); send(0); send(1); send(1);
    check("t1_cnt_ovl", 0, cnt0, 8'd2);
    check("t2_cnt_novl", 1, cnt1, 8'd1);

    // en gaps between bits 2 and 3 keep the partial match
    do_reset();
    send(1); send(0);
    repeat (3) step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    send(1); send(1);
    check("t3_cnt", 0, cnt0, 8'd1);

    // All-zero pattern: fill gating blocks the first three zeros
    do_reset();
    step(1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
    repeat (4) send(0);
    check("t4_cnt", 0, cnt0, 8'd1);

    // All-ones pattern: consecutive pulses, 2-bit counter saturates
    do_reset();
    step(1'b0, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b0);
    repeat (8) send(1);
    check("t5_sat", 2, {6'b0, cnt2}, 8'd3);
    check("t5_cnt", 0, cnt0, 8'd5);
    step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
    check("t5_clr_hit", 2, {6'b0, cnt2}, 8'd1);

    // Reset mid-match discards history and restores the default pattern
    step(1'b0, 1'b0, 1'b1, 4'b0110, 1'b0, 1'b0);
    do_reset();
    send(1); send(0); send(1);
    do_reset();
    send(1);
    check("t6_cnt", 0, cnt0, 8'd0);
    check("t6_out", 0, {7'b0, out_w[0]}, 8'd0);
    send(0); send(1); send(1);
    check("t6_pat", 0, cnt0, 8'd1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      bit e, d, ld, clr, rst;
      logic [3:0] np;
      rst = ($urandom % 60) == 0;
      ld  = ($urandom % 30) == 0;
      clr = ($urandom % 25) == 0;
      e   = ($urandom % 4) != 0;
      d   = 1'($urandom);
      np  = 4'($urandom);
      step(e, d, ld, np, clr, rst);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
